nn_layer_engine: RTL and testbench
==================================

Name: nn_layer_engine

Overview:
Parametrised successor to the single-pass neural_network datapath: a sequenced fully-connected inference engine.
- Holds a weight memory of LAYER_DEPTH x LAYER_SIZE x LAYER_SIZE signed fixed-point values and a ping-pong activation buffer.
- After a start request, runs a runtime-selectable number of layers using one time-multiplexed MAC with a selectable activation.
- Streams the final layer out over a valid/ready handshake.

Parameters:
- BIT_SIZE, 16, signed two's-complement data/weight width.
- LAYER_SIZE, 4, nodes per layer (inputs = outputs per layer).
- LAYER_DEPTH, 4, maximum number of layers.
- FRAC_BITS, 8, fractional bits of the fixed-point format (1.0 = 2^FRAC_BITS).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_we  in  1  weight write strobe.
- w_layer  in  clog2(LAYER_DEPTH)  weight layer index.
- w_node  in  clog2(LAYER_SIZE)  destination node index.
- w_src  in  clog2(LAYER_SIZE)  source activation index.
- w_data  in  BIT_SIZE  weight value.
- x_we  in  1  input write strobe (writes activation bank 0).
- x_idx  in  clog2(LAYER_SIZE)  input index.
- x_data  in  BIT_SIZE  input value.
- n_layers  in  clog2(LAYER_DEPTH+1)  layers to run; sampled at start.
- act_mode  in  2  0 identity, 1 ReLU, 2 leaky ReLU (negative >>> 3), 3 reserved (= identity); sampled at start.
- start  in  1  run request, accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last output handshake.
- y_valid  out  1  output data valid.
- y_ready  in  1  consumer ready.
- y_idx  out  clog2(LAYER_SIZE)  node index of y_data.
- y_data  out  BIT_SIZE  output activation.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; all counters are 0.
  - busy, done, y_valid, y_idx and y_data are 0.
  - Weight and activation memories are NOT cleared.
- FSM states: IDLE, MAC, WB, OUT, DONE.
- IDLE:
  - w_we/x_we write memories on the edge.
  - start=1 latches n_layers and act_mode.
  - Next state is MAC, or OUT when the effective layer count is 0.
- Effective layer count is min(n_layers, LAYER_DEPTH).
- MAC: one product per cycle.
  - acc += w[l][n][s] * a_cur[s] for s = 0..LAYER_SIZE-1, i.e. LAYER_SIZE cycles.
  - Accumulator width is 2*BIT_SIZE + clog2(LAYER_SIZE); there is no overflow inside the accumulator.
- WB (1 cycle):
  - Arithmetic shift of acc right by FRAC_BITS (floor).
  - Apply activation.
  - Saturate to [-2^(BIT_SIZE-1), 2^(BIT_SIZE-1)-1].
  - Write the result to a_nxt[n] and clear acc.
  - Next: MAC for the next node. After the last node, swap banks; the next layer, or OUT after the last layer.
- Timing per layer: (LAYER_SIZE+1) cycles per node, LAYER_SIZE*(LAYER_SIZE+1) cycles per layer.
- OUT:
  - y_valid=1, with y_idx/y_data = final bank entry k, starting at k=0.
  - A transfer occurs on an edge with y_valid & y_ready; the engine then advances k.
  - While y_ready=0, y_data and y_idx are held stable.
  - After k = LAYER_SIZE-1 is transferred, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- busy=1 in MAC, WB and OUT.
- Ignored requests:
  - start while not in IDLE is ignored.
  - w_we/x_we while not in IDLE are ignored (no memory change).
- n_layers=0: OUT streams bank 0 unchanged.
- The final result bank is (effective layers mod 2). Input bank 0 is overwritten by layer 2 outputs when depth ≥ 2.
- Reset mid-run: the engine aborts immediately. A new start after reset recomputes using the retained weights; inputs must be rewritten if depth ≥ 2.

Decomposition:
- Shared package nn_pkg:
  - act_mode_t enum (ACT_ID, ACT_RELU, ACT_LEAKY, ACT_RSVD).
  - engine_state_t enum.
  - Function sat_to_bits (saturating narrow).
  - Accumulator-width localparam.
- Sub-module nn_mac_unit: accumulator register, clear/accumulate control, shift, activation, saturation; combinational result output. The parent holds the FSM, memories and handshake.

Test Plan:
- Identity weights (w[l][n][n]=256, others 0), x=[100,-200,300,-400], n_layers=4, act 0 -> y=[100,-200,300,-400]; done occurs 80 cycles of compute + 4 transfers after busy rises.
- Same weights, n_layers=1, act 1 (ReLU) -> y=[100,0,300,0]. With act 2 (leaky) -> y=[100,-25,300,-50].
- Saturation: layer-0 row 0 all weights 256, x all 32767, n_layers=1 -> y[0]=32767. With x all -32768 -> y[0]=-32768.
- Backpressure: y_ready=0 for 3 cycles while y_idx=1 -> y_valid stays 1, y_idx=1 and y_data unchanged; no skip or duplicate; done occurs only after idx 3 transfers.
- n_layers=0 with x=[1,2,3,4] -> OUT is entered immediately and streams [1,2,3,4]; n_layers=7 behaves identically to 4.
- Control hazards:
  - start and w_we pulsed during MAC -> no restart, weights unchanged.
  - rst=0 mid-MAC -> busy and y_valid are 0 immediately.
  - Re-run after reset with inputs rewritten -> matches the original result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types, defaults and the saturating narrow used by the layer engine.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_WB   = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } engine_state_t;

    function automatic int acc_width(input int bit_size, input int layer_size);
        return 2 * bit_size + $clog2(layer_size);
    endfunction

    localparam int DEF_BIT_SIZE   = 16;
    localparam int DEF_LAYER_SIZE = 4;
    localparam int DEF_ACC_W      = acc_width(DEF_BIT_SIZE, DEF_LAYER_SIZE);

    // Clamp a sign-extended value into the signed range of 'bits' bits.
    function automatic logic signed [63:0] sat_to_bits(input logic signed [63:0] v,
                                                       input int unsigned      bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Time-multiplexed multiply-accumulate with floor shift, activation and saturation.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int BIT_SIZE   = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       acc_en,
    input  logic signed [BIT_SIZE-1:0] w,
    input  logic signed [BIT_SIZE-1:0] a,
    input  act_mode_t                  act_mode,
    output logic signed [BIT_SIZE-1:0] result
);

    logic signed [2*BIT_SIZE-1:0] w_ext, a_ext, prod;
    logic signed [ACC_W-1:0]      prod_ext, acc_q, shifted, activ;

    assign w_ext    = {{BIT_SIZE{w[BIT_SIZE-1]}}, w};
    assign a_ext    = {{BIT_SIZE{a[BIT_SIZE-1]}}, a};
    assign prod     = w_ext * a_ext;
    assign prod_ext = {{(ACC_W-2*BIT_SIZE){prod[2*BIT_SIZE-1]}}, prod};

    // Accumulator is cleared on abort so a restarted run never sees a stale partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        activ = shifted;
        case (act_mode)
            ACT_RELU:  if (shifted[ACC_W-1]) activ = '0;
            ACT_LEAKY: if (shifted[ACC_W-1]) activ = shifted >>> 3;
            default:   activ = shifted;
        endcase
    end

    assign result = BIT_SIZE'(sat_to_bits({{(64-ACC_W){activ[ACC_W-1]}}, activ}, BIT_SIZE));

endmodule

// File: rtl/nn_layer_engine.sv
// Sequenced fully-connected inference engine: weight memory, ping-pong activations,
// one shared MAC and a valid/ready output stream of the final layer.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter  int BIT_SIZE    = 16,
    parameter  int LAYER_SIZE  = 4,
    parameter  int LAYER_DEPTH = 4,
    parameter  int FRAC_BITS   = 8,
    localparam int LW          = $clog2(LAYER_DEPTH),
    localparam int NW          = $clog2(LAYER_SIZE),
    localparam int CW          = $clog2(LAYER_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_we,
    input  logic [LW-1:0]              w_layer,
    input  logic [NW-1:0]              w_node,
    input  logic [NW-1:0]              w_src,
    input  logic signed [BIT_SIZE-1:0] w_data,
    input  logic                       x_we,
    input  logic [NW-1:0]              x_idx,
    input  logic signed [BIT_SIZE-1:0] x_data,
    input  logic [CW-1:0]              n_layers,
    input  logic [1:0]                 act_mode,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [NW-1:0]              y_idx,
    output logic signed [BIT_SIZE-1:0] y_data
);

    localparam logic [NW-1:0] NODE_LAST = NW'(LAYER_SIZE - 1);

    logic signed [BIT_SIZE-1:0] wmem [LAYER_DEPTH][LAYER_SIZE][LAYER_SIZE];
    logic signed [BIT_SIZE-1:0] act  [2][LAYER_SIZE];

    engine_state_t state;
    act_mode_t     act_q;
    logic [CW-1:0] eff, eff_in;
    logic [LW-1:0] layer;
    logic [NW-1:0] node, src, k;
    logic          cur;
    logic signed [BIT_SIZE-1:0] mac_result;

    assign eff_in = (n_layers > CW'(LAYER_DEPTH)) ? CW'(LAYER_DEPTH) : n_layers;

    nn_mac_unit #(
        .BIT_SIZE  (BIT_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (acc_width(BIT_SIZE, LAYER_SIZE))
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_WB),
        .acc_en   (state == S_MAC),
        .w        (wmem[layer][node][src]),
        .a        (act[cur][src]),
        .act_mode (act_q),
        .result   (mac_result)
    );

    // Memories are never reset; host writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && w_we) wmem[w_layer][w_node][w_src] <= w_data;
        if (state == S_IDLE && x_we) act[1'b0][x_idx] <= x_data;
        if (state == S_WB)           act[~cur][node] <= mac_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            act_q   <= ACT_ID;
            eff     <= '0;
            layer   <= '0;
            node    <= '0;
            src     <= '0;
            k       <= '0;
            cur     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        act_q <= act_mode_t'(act_mode);
                        eff   <= eff_in;
                        layer <= '0;
                        node  <= '0;
                        src   <= '0;
                        k     <= '0;
                        cur   <= 1'b0;
                        busy  <= 1'b1;
                        if (eff_in == '0) begin
                            state   <= S_OUT;
                            y_valid <= 1'b1;
                        end else begin
                            state <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    src <= (src == NODE_LAST) ? '0 : src + NW'(1);
                    if (src == NODE_LAST) state <= S_WB;
                end
                S_WB: begin
                    state <= S_MAC;
                    if (node == NODE_LAST) begin
                        // Freshly written bank becomes the source of the next layer.
                        node <= '0;
                        cur  <= ~cur;
                        if (CW'(layer) == eff - CW'(1)) begin
                            state   <= S_OUT;
                            y_valid <= 1'b1;
                        end else begin
                            layer <= layer + LW'(1);
                        end
                    end else begin
                        node <= node + NW'(1);
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        if (k == NODE_LAST) begin
                            k       <= '0;
                            y_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            k <= k + NW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign y_idx  = k;
    assign y_data = y_valid ? act[cur][k] : '0;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench for nn_layer_engine with hand-computed expectations.
module tb_nn_layer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we;
    logic [1:0]  w_layer;
    logic [1:0]  w_node;
    logic [1:0]  w_src;
    logic signed [15:0] w_data;
    logic        x_we;
    logic [1:0]  x_idx;
    logic signed [15:0] x_data;
    logic [2:0]  n_layers;
    logic [1:0]  act_mode;
    logic        start;
    logic        busy;
    logic        done;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_idx;
    logic signed [15:0] y_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nn_layer_engine dut (
        .clk      (clk),
        .rst      (rst),
        .w_we     (w_we),
        .w_layer  (w_layer),
        .w_node   (w_node),
        .w_src    (w_src),
        .w_data   (w_data),
        .x_we     (x_we),
        .x_idx    (x_idx),
        .x_data   (x_data),
        .n_layers (n_layers),
        .act_mode (act_mode),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_idx    (y_idx),
        .y_data   (y_data)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int l, input int n, input int s, input int v);
        w_layer = 2'(l); w_node = 2'(n); w_src = 2'(s); w_data = 16'(v); w_we = 1'b1;
        tick();
        w_we = 1'b0;
    endtask

    task automatic identity();
        for (int l = 0; l < 4; l++)
            for (int n = 0; n < 4; n++)
                for (int s = 0; s < 4; s++)
                    set_w(l, n, s, (n == s) ? 256 : 0);
    endtask

    task automatic set_x(input int v0, input int v1, input int v2, input int v3);
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            x_idx = 2'(i); x_data = 16'(v[i]); x_we = 1'b1;
            tick();
        end
        x_we = 1'b0;
    endtask

    task automatic start_run(input int nl, input int am);
        n_layers = 3'(nl); act_mode = 2'(am); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams the result with y_ready high, checking index/data per transfer and latency.
    task automatic collect(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int first, input int exp_cyc);
        int ex[4];
        int idx;
        int cyc;
        ex  = '{e0, e1, e2, e3};
        idx = first;
        cyc = 0;
        y_ready = 1'b1;
        while (done !== 1'b1 && cyc < 400) begin
            if (y_valid === 1'b1) begin
                if (idx < 4) begin
                    chk($sformatf("%s_idx%0d", tag, idx), 32'(y_idx), idx);
                    chk($sformatf("%s_y%0d", tag, idx), 32'($signed(y_data)), ex[idx]);
                end
                idx++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_count"}, idx, 4);
        if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc, exp_cyc);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b0; w_we = 1'b0; w_layer = '0; w_node = '0; w_src = '0; w_data = '0;
        x_we = 1'b0; x_idx = '0; x_data = '0; n_layers = '0; act_mode = '0;
        start = 1'b0; y_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(y_valid), 0);
        chk("rst_idx", 32'(y_idx), 0);
        chk("rst_data", 32'($signed(y_data)), 0);
        #5 rst = 1'b1;
        tick();

        identity();
        set_x(100, -200, 300, -400);
        start_run(4, 0);
        chk("id4_busy", 32'(busy), 1);
        collect("id4", 100, -200, 300, -400, 0, 84);

        set_x(100, -200, 300, -400);
        start_run(1, 1);
        collect("relu", 100, 0, 300, 0, 0, 24);

        set_x(100, -200, 300, -400);
        start_run(1, 2);
        collect("leaky", 100, -25, 300, -50, 0, 24);

        set_x(100, -200, 300, -400);
        start_run(7, 0);
        collect("n7", 100, -200, 300, -400, 0, 84);

        set_x(1, 2, 3, 4);
        y_ready = 1'b0;
        start_run(0, 0);
        chk("n0_valid", 32'(y_valid), 1);
        chk("n0_idx0", 32'(y_idx), 0);
        chk("n0_y0", 32'($signed(y_data)), 1);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), 32'(y_valid), 1);
            chk($sformatf("bp_idx%0d", i), 32'(y_idx), 1);
            chk($sformatf("bp_data%0d", i), 32'($signed(y_data)), 2);
            chk($sformatf("bp_done%0d", i), 32'(done), 0);
        end
        collect("bp", 1, 2, 3, 4, 1, 3);

        set_x(100, -200, 300, -400);
        start_run(1, 0);
        repeat (6) tick();
        start = 1'b1;
        w_layer = 2'd0; w_node = 2'd1; w_src = 2'd1; w_data = 16'sd0; w_we = 1'b1;
        tick();
        start = 1'b0; w_we = 1'b0;
        chk("hz_busy", 32'(busy), 1);
        collect("hz", 100, -200, 300, -400, 0, 17);
        set_x(100, -200, 300, -400);
        start_run(1, 0);
        collect("hz_rerun", 100, -200, 300, -400, 0, 24);

        set_x(100, -200, 300, -400);
        start_run(4, 0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(y_valid), 0);
        chk("abort_done", 32'(done), 0);
        #2 rst = 1'b1;
        tick();
        set_x(100, -200, 300, -400);
        start_run(4, 0);
        collect("rerun", 100, -200, 300, -400, 0, 84);

        for (int s = 1; s < 4; s++) set_w(0, 0, s, 256);
        set_x(32767, 32767, 32767, 32767);
        start_run(1, 0);
        collect("sat_hi", 32767, 32767, 32767, 32767, 0, 24);
        set_x(-32768, -32768, -32768, -32768);
        start_run(1, 0);
        collect("sat_lo", -32768, -32768, -32768, -32768, 0, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
